divisor_seq: RTL

DIVISOR_SEQ -- requirements
Module: divisor_seq

---
 rtl/divisor_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/divisor_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, with divide-by-zero flag.
// Define DIVZERO_STICKY_EN to make Erro sticky until clr_erro or reset.
`timescale 1ns/1ps
module divisor_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       Sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             clr_erro,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             Erro
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CALC    = 2'd1;
    localparam logic [1:0] FIM     = 2'd2;
    localparam logic [2:0] SEL_DIV = 3'b011;
    localparam int         CW      = $clog2(WIDTH + 1);

    logic [1:0]       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] div_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic             done_reg;
    logic             erro_reg;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             accept;
    logic             last_step;
    logic             b_zero;
    logic             enter_fim;
    logic             enter_err;

    // Trial subtraction is WIDTH+1 bits; since trial < 2*divisor, the sign bit alone
    // tells whether the divisor fits.
    always_comb begin
        trial     = {rem_reg, quo_reg[WIDTH-1]};
        diff      = trial - {1'b0, div_reg};
        fits      = ~diff[WIDTH];
        rem_next  = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_next  = {quo_reg[WIDTH-2:0], fits};
        // done_reg high means the FSM is in its first IDLE cycle after FIM; a start there is dropped
        accept    = (state_reg == IDLE) && start && (Sel == SEL_DIV) && !done_reg;
        last_step = (cnt_reg == CW'(WIDTH - 1));
        b_zero    = (B == '0);
        enter_err = accept && b_zero;
        enter_fim = enter_err || ((state_reg == CALC) && last_step);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            div_reg   <= '0;
            quo_reg   <= '0;
            rem_reg   <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= (state_reg == FIM);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        div_reg <= B;
                        quo_reg <= A;
                        rem_reg <= '0;
                        cnt_reg <= '0;
                        if (b_zero) begin
                            q_reg     <= '0;
                            r_reg     <= '0;
                            state_reg <= FIM;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (last_step) begin
                        q_reg     <= quo_next;
                        r_reg     <= rem_next;
                        state_reg <= FIM;
                    end
                end
                FIM:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef DIVZERO_STICKY_EN
    // Clear has priority over a divide-by-zero completing on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            erro_reg <= 1'b0;
        end else if (clr_erro) begin
            erro_reg <= 1'b0;
        end else if (enter_err) begin
            erro_reg <= 1'b1;
        end
    end
`else
    logic unused_clr_erro;
    assign unused_clr_erro = clr_erro;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            erro_reg <= 1'b0;
        end else if (enter_fim) begin
            erro_reg <= enter_err;
        end
    end
`endif

    assign Q    = q_reg;
    assign R    = r_reg;
    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign Erro = erro_reg;

endmodule
